// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Latches the segment word once per frame; adds a guard interval, leading-zero blanking and blink.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] display_all,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    ZERO       = 7'b1000000;

    logic [SW-1:0] r_slot_cnt;
    logic [1:0]    r_idx;
    logic [27:0]   r_in;
    logic [27:0]   r_frame;
    logic          r_frame_vld;
    logic [FW-1:0] r_frame_cnt;
    logic          r_blink_phase;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_tick;
    logic          w_frame_end;
    logic          w_z3, w_z2, w_z1;
    logic          w_blanked;
    logic          w_off;
    logic [6:0]    w_digit_seg;

    assign w_tick      = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_tick & (r_idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (w_tick) begin
            r_slot_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + SW'(1);
        end
    end

    // r_frame only moves at the end of a full scan so no digit is ever torn.
    // r_frame_vld keeps the anodes dark until the first real frame has been captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in        <= 28'hFFFFFFF;
            r_frame     <= 28'hFFFFFFF;
            r_frame_vld <= 1'b0;
        end else begin
            r_in <= display_all;
            if (w_frame_end) begin
                r_frame     <= r_in;
                r_frame_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!blink_en) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end

    assign w_z3 = (r_frame[27:21] == ZERO);
    assign w_z2 = w_z3 & (r_frame[20:14] == ZERO);
    assign w_z1 = w_z2 & (r_frame[13:7] == ZERO);

    always_comb begin
        w_blanked   = 1'b0;
        w_digit_seg = r_frame[6:0];
        case (r_idx)
            2'd3: begin
                w_blanked   = blank_lz & w_z3;
                w_digit_seg = r_frame[27:21];
            end
            2'd2: begin
                w_blanked   = blank_lz & w_z2;
                w_digit_seg = r_frame[20:14];
            end
            2'd1: begin
                w_blanked   = blank_lz & w_z1;
                w_digit_seg = r_frame[13:7];
            end
            default: begin
                w_blanked   = 1'b0;
                w_digit_seg = r_frame[6:0];
            end
        endcase
    end

    assign w_off = (r_slot_cnt < GUARD_END) | ~r_frame_vld | w_blanked
                 | (blink_en & r_blink_phase);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else if (w_off) begin
            r_an  <= 4'b1111;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_digit_seg;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios followed by random traffic,
// every cycle compared against a time-indexed behavioural model of the display.
module tb_seg7_scan_driver;

    localparam int RD = 4;
    localparam int G  = 1;
    localparam int BF = 2;
    localparam logic [6:0] ZERO = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] display_all;
    logic        blank_lz;
    logic        blink_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset release, the word seen one edge ago,
    // the word currently on display, and frames completed while blink is enabled.
    int          m_t;
    logic [27:0] m_in_prev;
    logic [27:0] m_frame;
    bit          m_vld;
    int          m_bcnt;

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(G), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .display_all(display_all),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] word4(input int d3, input int d2, input int d1, input int d0);
        return {pat(d3), pat(d2), pat(d1), pat(d0)};
    endfunction

    function automatic logic [6:0] rand_digit();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return ZERO;
        if (r < 8) return pat($urandom_range(0, 9));
        return 7'($urandom_range(0, 127));
    endfunction

    // A digit is blank when blanking is on, it is not the rightmost digit,
    // and it and every digit to its left read as zero.
    function automatic bit lz_blanked(input logic [27:0] frame, input int idx, input logic lz);
        if (!lz || idx == 0) return 1'b0;
        for (int j = idx; j < 4; j++)
            if (frame[7*j +: 7] != ZERO) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_in_prev = 28'hFFFFFFF;
        m_frame   = 28'hFFFFFFF;
        m_vld     = 1'b0;
        m_bcnt    = 0;
    endtask

    // One clock: predict the registered outputs from model state and the
    // current inputs, advance the model, then compare on the falling edge.
    task automatic step();
        logic [3:0] ea;
        logic [6:0] es;
        int         pos, idx;
        bit         off, phase, fend;
        pos   = m_t % RD;
        idx   = (m_t / RD) % 4;
        phase = ((m_bcnt / BF) % 2) == 1;
        off   = (pos < G) || !m_vld || lz_blanked(m_frame, idx, blank_lz) || (blink_en && phase);
        ea = 4'b1111;
        es = 7'h7F;
        if (!off) begin
            ea[idx] = 1'b0;
            es      = m_frame[7*idx +: 7];
        end
        fend = (m_t % (4*RD)) == (4*RD - 1);
        if (fend) begin
            m_frame = m_in_prev;
            m_vld   = 1'b1;
        end
        if (!blink_en) m_bcnt = 0;
        else if (fend) m_bcnt++;
        m_in_prev = display_all;
        m_t++;
        @(posedge clk);
        @(negedge clk);
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(es));
        chk("dp", 32'(dp), 32'd1);
        chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    // Called on a falling edge; reset lands mid-cycle, away from any clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        display_all = word4(1, 2, 3, 4);
        blank_lz    = 1'b0;
        blink_en    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_an", 32'(an), 32'hF);
        chk("init_seg", 32'(seg), 32'h7F);
        chk("init_dp", 32'(dp), 32'd1);
        #1 rst = 1'b0;

        // Reset: first frame dark, then scanning; reset again mid-slot with an=1110.
        repeat (34) step();
        chk("pre_rst_an", 32'(an), 32'hE);
        async_reset();

        // Frame latch: word changes mid-frame, old frame finishes first.
        repeat (38) step();
        display_all = {4{pat(9)}};
        repeat (40) step();

        // Leading-zero blanking, then disabled.
        display_all = word4(0, 0, 5, 0);
        blank_lz    = 1'b1;
        repeat (40) step();
        blank_lz = 1'b0;
        repeat (24) step();

        // All-zero score.
        display_all = word4(0, 0, 0, 0);
        blank_lz    = 1'b1;
        repeat (40) step();

        // Blink: run, drop during the dark phase, re-raise.
        display_all = word4(1, 2, 3, 4);
        blank_lz    = 1'b0;
        blink_en    = 1'b1;
        repeat (70) step();
        for (int i = 0; i < 80 && ((m_bcnt / BF) % 2) != 1; i++) step();
        chk("blink_dark_reached", 32'((m_bcnt / BF) % 2), 32'd1);
        repeat (3) step();
        blink_en = 1'b0;
        repeat (10) step();
        blink_en = 1'b1;
        repeat (80) step();
        blink_en = 1'b0;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0)
                display_all = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 1499) == 0) async_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
